// File: rtl/lightgun_arbiter.sv
// Shares the crosshair overlay and light-sensor path between two lightguns.
// Ownership alternates per frame slot, or is locked to a gun whose trigger was just pulled.
module lightgun_arbiter #(
  parameter int HOLD_FRAMES = 4,
  parameter int ALT_FRAMES  = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CE_PIX,
  input  logic       VDE,
  input  logic [1:0] EN,
  input  logic       MODE,
  input  logic [1:0] TARGET_IN,
  input  logic [1:0] SENSOR_IN,
  input  logic [1:0] TRIGGER_IN,
  output logic       TARGET,
  output logic       TARGET_SEL,
  output logic [1:0] SENSOR_OUT,
  output logic       OWNER,
  output logic       LOCKED,
  output logic [2:0] DBG_STATE
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SLOT0 = 3'd1;
  localparam logic [2:0] SLOT1 = 3'd2;
  localparam logic [2:0] LOCK0 = 3'd3;
  localparam logic [2:0] LOCK1 = 3'd4;

  logic [2:0] state_q, state_d;
  logic [3:0] hold_q, hold_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_lock_q, last_lock_d;
  logic [1:0] pend_q, pend_d;
  logic       vde_prev_q, vde_prev_d;
  logic [1:0] trig_prev_q, trig_prev_d;
  logic       target_q, target_d;
  logic       target_sel_q, target_sel_d;
  logic [1:0] sensor_q, sensor_d;
  logic       owner_q, owner_d;
  logic       locked_q, locked_d;

  logic       fb;
  logic [1:0] trig_rise;
  logic [1:0] pend_v;
  logic [1:0] pend_clr;
  logic       cur_gun;
  logic       other_gun;
  logic       is_lock;
  logic       lock_go;
  logic       lock_gun;
  logic       unl_ovl;
  logic [1:0] tgt_en;
  logic [1:0] sen_en;

  always_comb begin
    vde_prev_d  = CE_PIX ? VDE : vde_prev_q;
    fb          = CE_PIX & VDE & ~vde_prev_q;
    trig_prev_d = TRIGGER_IN;
    trig_rise   = TRIGGER_IN & ~trig_prev_q;
    pend_v      = pend_q & EN;
    cur_gun     = (state_q == SLOT1) || (state_q == LOCK1);
    other_gun   = ~cur_gun;
    is_lock     = (state_q == LOCK0) || (state_q == LOCK1);
  end

  // Frame-boundary state machine; a lock owner's own pend extends its lock,
  // the other gun's pend waits until the hold count runs out.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    cnt_d       = cnt_q;
    last_lock_d = last_lock_q;
    lock_go     = 1'b0;
    lock_gun    = 1'b0;
    if (fb) begin
      if (EN == 2'b00) begin
        state_d = IDLE;
      end else if (is_lock) begin
        if (pend_v[cur_gun]) begin
          lock_go  = 1'b1;
          lock_gun = cur_gun;
        end else if (hold_q != 4'd0) begin
          hold_d = hold_q - 4'd1;
        end else if (pend_v[other_gun]) begin
          lock_go  = 1'b1;
          lock_gun = other_gun;
        end else begin
          state_d = (EN[cur_gun] ? cur_gun : other_gun) ? SLOT1 : SLOT0;
          cnt_d   = 4'd0;
        end
      end else if (pend_v != 2'b00) begin
        lock_go  = 1'b1;
        lock_gun = (pend_v == 2'b11) ? ~last_lock_q : pend_v[1];
      end else if (state_q == IDLE) begin
        state_d = EN[0] ? SLOT0 : SLOT1;
        cnt_d   = 4'd0;
      end else if (!EN[cur_gun]) begin
        state_d = other_gun ? SLOT1 : SLOT0;
        cnt_d   = 4'd0;
      end else if (cnt_q == 4'(ALT_FRAMES - 1)) begin
        cnt_d = 4'd0;
        if (EN[other_gun]) state_d = other_gun ? SLOT1 : SLOT0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
      if (lock_go) begin
        state_d     = lock_gun ? LOCK1 : LOCK0;
        hold_d      = 4'(HOLD_FRAMES - 1);
        last_lock_d = lock_gun;
        cnt_d       = 4'd0;
      end
    end
    pend_clr = lock_go ? (lock_gun ? 2'b10 : 2'b01) : 2'b00;
    pend_d   = (pend_q & EN & ~pend_clr) | (trig_rise & EN);
  end

  always_comb begin
    unl_ovl = MODE & ~is_lock;
    tgt_en  = TARGET_IN & EN;
    sen_en  = SENSOR_IN & EN;
    if (state_q == IDLE)  target_d = 1'b0;
    else if (!unl_ovl)    target_d = tgt_en[cur_gun];
    else                  target_d = |tgt_en;
    // In the shared overlay gun 0 wins where both crosshairs overlap.
    target_sel_d = unl_ovl ? (tgt_en[1] & ~TARGET_IN[0]) : cur_gun;
    if (unl_ovl)               sensor_d = sen_en;
    else if (state_q == IDLE)  sensor_d = 2'b00;
    else                       sensor_d = sen_en & (cur_gun ? 2'b10 : 2'b01);
    owner_d  = cur_gun;
    locked_d = is_lock;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      hold_q       <= 4'd0;
      cnt_q        <= 4'd0;
      last_lock_q  <= 1'b1;
      pend_q       <= 2'b00;
      vde_prev_q   <= 1'b0;
      trig_prev_q  <= 2'b00;
      target_q     <= 1'b0;
      target_sel_q <= 1'b0;
      sensor_q     <= 2'b00;
      owner_q      <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      cnt_q        <= cnt_d;
      last_lock_q  <= last_lock_d;
      pend_q       <= pend_d;
      vde_prev_q   <= vde_prev_d;
      trig_prev_q  <= trig_prev_d;
      target_q     <= target_d;
      target_sel_q <= target_sel_d;
      sensor_q     <= sensor_d;
      owner_q      <= owner_d;
      locked_q     <= locked_d;
    end
  end

  assign TARGET     = target_q;
  assign TARGET_SEL = target_sel_q;
  assign SENSOR_OUT = sensor_q;
  assign OWNER      = owner_q;
  assign LOCKED     = locked_q;
  assign DBG_STATE  = state_q;

endmodule

// File: tb/tb_lightgun_arbiter.sv
// Directed bench for lightgun_arbiter: alternation, trigger locks, ties,
// lock extension, single-gun operation, pixel-enable gating and reset mid-lock.
module tb_lightgun_arbiter;

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic       CE_PIX = 1'b1;
  logic       VDE = 1'b0;
  logic [1:0] EN = 2'b00;
  logic       MODE = 1'b0;
  logic [1:0] TARGET_IN = 2'b00;
  logic [1:0] SENSOR_IN = 2'b00;
  logic [1:0] TRIGGER_IN = 2'b00;
  logic       TARGET;
  logic       TARGET_SEL;
  logic [1:0] SENSOR_OUT;
  logic       OWNER;
  logic       LOCKED;
  logic [2:0] DBG_STATE;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  lightgun_arbiter #(.HOLD_FRAMES(4), .ALT_FRAMES(1)) dut (
    .CLK(clk), .RESET(RESET), .CE_PIX(CE_PIX), .VDE(VDE), .EN(EN), .MODE(MODE),
    .TARGET_IN(TARGET_IN), .SENSOR_IN(SENSOR_IN), .TRIGGER_IN(TRIGGER_IN),
    .TARGET(TARGET), .TARGET_SEL(TARGET_SEL), .SENSOR_OUT(SENSOR_OUT),
    .OWNER(OWNER), .LOCKED(LOCKED), .DBG_STATE(DBG_STATE)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One frame: VDE low then high; the boundary lands on the first high clock.
  task automatic frame();
    VDE = 1'b0;
    cyc(3);
    VDE = 1'b1;
    cyc(3);
  endtask

  task automatic trig(input logic [1:0] m);
    TRIGGER_IN = m;
    cyc(1);
    TRIGGER_IN = 2'b00;
    cyc(1);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    VDE = 1'b0;
    CE_PIX = 1'b1;
    TRIGGER_IN = 2'b00;
    cyc(2);
    RESET = 1'b0;
    cyc(1);
  endtask

  task automatic test_reset();
    logic [8:0] obs;
    EN = 2'b11; MODE = 1'b0; SENSOR_IN = 2'b11; TARGET_IN = 2'b11;
    do_reset();
    obs = {DBG_STATE, LOCKED, OWNER, TARGET, TARGET_SEL, SENSOR_OUT};
    total++;
    if (obs !== 9'b0) begin
      $display("FAIL reset_state got=%b exp=%b", obs, 9'b0); bad++;
    end
  endtask

  task automatic test_alternate();
    logic [4:0] obs, exp;
    logic o;
    EN = 2'b11; MODE = 1'b0; SENSOR_IN = 2'b11; TARGET_IN = 2'b01;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      frame();
      o = 1'(i % 2);
      exp = {1'b0, o, ~o, o ? 2'b10 : 2'b01};
      obs = {LOCKED, OWNER, TARGET, SENSOR_OUT};
      total++;
      if (obs !== exp) begin
        $display("FAIL alternate[%0d] got=%b exp=%b", i, obs, exp); bad++;
      end
    end
  endtask

  task automatic test_lock1();
    logic [5:0] obs, exp;
    EN = 2'b11; MODE = 1'b1; SENSOR_IN = 2'b11; TARGET_IN = 2'b11;
    do_reset();
    frame();
    obs = {LOCKED, OWNER, TARGET, TARGET_SEL, SENSOR_OUT};
    total++;
    if (obs !== 6'b0_0_1_0_11) begin
      $display("FAIL lock1_pre got=%b exp=%b", obs, 6'b0_0_1_0_11); bad++;
    end
    TARGET_IN = 2'b01;
    trig(2'b10);
    for (int i = 1; i <= 5; i++) begin
      frame();
      exp = (i <= 4) ? 6'b1_1_0_1_10 : 6'b0_1_1_0_11;
      obs = {LOCKED, OWNER, TARGET, TARGET_SEL, SENSOR_OUT};
      total++;
      if (obs !== exp) begin
        $display("FAIL lock1[%0d] got=%b exp=%b", i, obs, exp); bad++;
      end
    end
    TARGET_IN = 2'b11;
    cyc(2);
    total++;
    if (TARGET_SEL !== 1'b0) begin
      $display("FAIL overlap_sel got=%b exp=0", TARGET_SEL); bad++;
    end
    TARGET_IN = 2'b10;
    cyc(2);
    total++;
    if ({TARGET, TARGET_SEL} !== 2'b11) begin
      $display("FAIL gun1_sel got=%b exp=11", {TARGET, TARGET_SEL}); bad++;
    end
  endtask

  task automatic test_tie();
    logic [1:0] obs, exp;
    EN = 2'b11; MODE = 1'b0; SENSOR_IN = 2'b11; TARGET_IN = 2'b00;
    do_reset();
    trig(2'b11);
    for (int i = 1; i <= 9; i++) begin
      frame();
      exp = (i <= 4) ? 2'b10 : (i <= 8) ? 2'b11 : 2'b01;
      obs = {LOCKED, OWNER};
      total++;
      if (obs !== exp) begin
        $display("FAIL tie[%0d] got=%b exp=%b", i, obs, exp); bad++;
      end
    end
  endtask

  task automatic test_extend();
    logic [1:0] obs, exp;
    EN = 2'b11; MODE = 1'b0; SENSOR_IN = 2'b11; TARGET_IN = 2'b00;
    do_reset();
    trig(2'b01);
    for (int i = 1; i <= 7; i++) begin
      frame();
      exp = (i <= 6) ? 2'b10 : 2'b00;
      obs = {LOCKED, OWNER};
      total++;
      if (obs !== exp) begin
        $display("FAIL extend[%0d] got=%b exp=%b", i, obs, exp); bad++;
      end
      if (i == 2) trig(2'b01);
    end
  endtask

  task automatic test_single_en();
    logic [4:0] obs;
    EN = 2'b01; MODE = 1'b1; SENSOR_IN = 2'b11; TARGET_IN = 2'b10;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      frame();
      obs = {OWNER, TARGET, TARGET_SEL, SENSOR_OUT};
      total++;
      if (obs !== 5'b0_0_0_01) begin
        $display("FAIL single_en[%0d] got=%b exp=%b", i, obs, 5'b0_0_0_01); bad++;
      end
    end
    EN = 2'b00;
    cyc(1);
    total++;
    if ({DBG_STATE, SENSOR_OUT} !== 5'b001_00) begin
      $display("FAIL en_drop got=%b exp=%b", {DBG_STATE, SENSOR_OUT}, 5'b001_00); bad++;
    end
    frame();
    obs = {OWNER, TARGET, TARGET_SEL, SENSOR_OUT};
    total++;
    if ({DBG_STATE, obs} !== 8'b0) begin
      $display("FAIL en_idle got=%b exp=%b", {DBG_STATE, obs}, 8'b0); bad++;
    end
  endtask

  task automatic test_ce_gate();
    EN = 2'b11; MODE = 1'b0;
    do_reset();
    cyc(2);
    CE_PIX = 1'b0;
    VDE = 1'b1;
    cyc(3);
    total++;
    if (DBG_STATE !== 3'd0) begin
      $display("FAIL ce_hold got=%0d exp=0", DBG_STATE); bad++;
    end
    CE_PIX = 1'b1;
    cyc(2);
    total++;
    if (DBG_STATE !== 3'd1) begin
      $display("FAIL ce_fb got=%0d exp=1", DBG_STATE); bad++;
    end
  endtask

  task automatic test_reset_mid_lock();
    logic [5:0] obs;
    EN = 2'b11; MODE = 1'b0; SENSOR_IN = 2'b11; TARGET_IN = 2'b11;
    do_reset();
    trig(2'b10);
    frame();
    total++;
    if ({LOCKED, OWNER} !== 2'b11) begin
      $display("FAIL rst_lock_pre got=%b exp=11", {LOCKED, OWNER}); bad++;
    end
    frame();
    trig(2'b01);
    VDE = 1'b0;
    cyc(1);
    RESET = 1'b1;
    cyc(1);
    obs = {LOCKED, OWNER, TARGET, TARGET_SEL, SENSOR_OUT};
    total++;
    if ({DBG_STATE, obs} !== 9'b0) begin
      $display("FAIL rst_mid_lock got=%b exp=%b", {DBG_STATE, obs}, 9'b0); bad++;
    end
    RESET = 1'b0;
    cyc(1);
    frame();
    total++;
    if ({LOCKED, OWNER} !== 2'b00) begin
      $display("FAIL rst_pend_drop got=%b exp=00", {LOCKED, OWNER}); bad++;
    end
    trig(2'b11);
    frame();
    total++;
    if ({LOCKED, OWNER} !== 2'b10) begin
      $display("FAIL rst_tie got=%b exp=10", {LOCKED, OWNER}); bad++;
    end
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_lock1();
    test_tie();
    test_extend();
    test_single_en();
    test_ce_gate();
    test_reset_mid_lock();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lightgun_arbiter.md
Name: lightgun_arbiter

Overview:
- Shares the on-screen crosshair overlay and the light-sensor path between two lightgun instances, one per controller port.
- Each frame it grants one gun ownership of the overlay and sensor, in one of two ways:
  - alternating ownership every ALT_FRAMES frames, or
  - giving ownership to a gun whose trigger was just pulled, for HOLD_FRAMES frames.
- Sits between the two lightgun blocks and the video mixer / port input logic.

Parameters:
- HOLD_FRAMES, 4: frames a triggered gun keeps exclusive ownership (1..15).
- ALT_FRAMES, 1: frames per alternation slot when no lock is active (1..15).

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- CE_PIX  in  1  pixel clock enable
- VDE  in  1  vertical display enable
- EN  in  2  per-port gun enable (bit n = port n has a lightgun)
- MODE  in  1  0 = alternate overlays, 1 = overlay both when unlocked
- TARGET_IN  in  2  per-gun crosshair pixel
- SENSOR_IN  in  2  per-gun sensor output
- TRIGGER_IN  in  2  per-gun trigger, level
- TARGET  out  1  combined crosshair pixel to mixer
- TARGET_SEL  out  1  gun whose crosshair is on TARGET (colour select)
- SENSOR_OUT  out  2  gated sensor per port
- OWNER  out  1  current owning gun
- LOCKED  out  1  trigger lock active

Behaviour:
- Reset: all outputs 0. State IDLE. Pending flags cleared. Frame and hold counters 0. last_lock = 1, so gun 0 wins the first tie.
- Frame boundary (fb): one-CLK pulse when CE_PIX=1, VDE=1 and the previous CE_PIX sample of VDE was 0. All state transitions happen only on fb.
- Trigger latch, every CLK:
  - A rising edge on TRIGGER_IN[n] (previous-CLK compare) with EN[n]=1 sets pend[n].
  - pend[n] clears when that gun enters LOCKn, or when EN[n]=0.
- States: IDLE, SLOT0, SLOT1, LOCK0, LOCK1. On fb, evaluated in this priority order:
  1. EN==0 → IDLE.
  2. Any pend:
     - Only one pending → LOCKn.
     - Both pending → gun != last_lock.
     - Entering LOCKn: hold = HOLD_FRAMES-1, last_lock = n.
     - A pend for the current lock owner reloads hold (lock extension).
     - A loser's pend stays set and is served when the current lock ends.
  3. In LOCKn:
     - hold != 0 → decrement.
     - hold == 0 → SLOTn if EN[n], else SLOT of the other gun. frame count = 0.
  4. In SLOTn:
     - EN[n]=0 → SLOT of the other gun.
     - Else increment frame count. At ALT_FRAMES-1, go to SLOT of the other gun if it is enabled, else stay. Count resets to 0 on either outcome.
  5. In IDLE with EN != 0 → SLOT of the lowest enabled gun.
- A mid-frame EN drop does not change state, but gating below uses live EN.
- Outputs are registered, one CLK latency from inputs. owner = state's gun.
  - TARGET:
    - IDLE → 0.
    - LOCKn, or MODE=0 → TARGET_IN[owner] & EN[owner].
    - MODE=1 and unlocked → OR over n of (TARGET_IN[n] & EN[n]).
  - TARGET_SEL:
    - Equals owner, except in MODE=1 unlocked.
    - There it is 1 only when TARGET_IN[1] & EN[1] & ~TARGET_IN[0] (gun 0 wins overlap).
  - SENSOR_OUT[n]:
    - MODE=1 unlocked → SENSOR_IN[n] & EN[n].
    - Otherwise → SENSOR_IN[n] & EN[n] & (owner==n) & (state != IDLE).
  - OWNER = owner (0 in IDLE). LOCKED = 1 in LOCK0/LOCK1.
- Simultaneous fb and trigger edge on the same CLK: the edge is latched, then acted on at the next fb, not this one.
- RESET mid-lock: returns to IDLE in the same CLK and drops all pends.

Test Plan:
- EN=11, MODE=0, ALT_FRAMES=1, no triggers, 6 frames → OWNER toggles 0,1,0,1… on each fb. SENSOR_OUT[1]=0 while OWNER=0 with SENSOR_IN=11.
- EN=11, gun 1 trigger edge mid-frame → next fb: LOCKED=1, OWNER=1. Stays locked for exactly 4 fb (HOLD_FRAMES=4), then SLOT1. MODE=1 overlay is suppressed during the lock.
- Both triggers rise on the same CLK after reset → LOCK0 for 4 frames, then LOCK1 for 4 frames (pend[1] retained), then SLOT1.
- Gun 0 locked, re-trigger gun 0 at lock frame 2 → hold reloads; total lock length is 6 frames.
- EN=01, MODE=1 → OWNER stays 0 every fb. TARGET_IN=10 gives TARGET=0. Drop EN to 00 → SENSOR_OUT=00 the next CLK, IDLE at next fb.
- RESET asserted during LOCK1 → next CLK: all outputs 0, LOCKED=0. The first post-reset trigger tie goes to gun 0.
